freq_counter_mc: RTL and testbench

Multi-channel, parametrised frequency counter for the signal-processing fabric. It takes a stream of signed samples, one lane per channel, on an AXI-Stream slave and detects rising crossings per channel with a Schmitt trigger (programmable hysteresis). Over a programmable gate of N accepted samples it counts crossings, then emits one result word per channel as an AXI-Stream frame with backpressure support and overrun reporting. It is the successor of the single-channel, fixed-width `frequency_counter`.

---
 rtl/freq_counter_mc.sv | 110 +++++++++++
 tb/tb_freq_counter_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_mc.sv
// freq_counter_mc: multi-channel Schmitt-trigger crossing counter with a gated,
// AXI-Stream framed result output.
//   clk, rst (sync, active-low)
//   S_AXIS_IN_tdata/tvalid  : one signed DATA_W lane per channel, always accepted
//   Ncycles                 : gate length in accepted samples (0 acts as 1)
//   hyst                    : unsigned hysteresis threshold
//   clr_ovr                 : clears overrun
//   M_AXIS_OUT_*            : one CNT_W result word per channel, tuser = channel, tlast on CH-1
//   counter_output          : results of the last delivered gate
//   overrun                 : sticky, a completed gate was dropped
module freq_counter_mc #(
   parameter int DATA_W = 16,
   parameter int CH     = 2,
   parameter int CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH*DATA_W-1:0]  S_AXIS_IN_tdata,
   input  logic                  S_AXIS_IN_tvalid,
   input  logic [31:0]           Ncycles,
   input  logic [DATA_W-1:0]     hyst,
   input  logic                  clr_ovr,
   output logic [CNT_W-1:0]      M_AXIS_OUT_tdata,
   output logic [2:0]            M_AXIS_OUT_tuser,
   output logic                  M_AXIS_OUT_tlast,
   output logic                  M_AXIS_OUT_tvalid,
   input  logic                  M_AXIS_OUT_tready,
   output logic [CH*CNT_W-1:0]   counter_output,
   output logic                  overrun
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [CH-1:0] hi, hi_nxt;
   logic [CH*CNT_W-1:0] cnt, cnt_nxt;
   logic [31:0] gate_cnt, shadow;
   logic signed [DATA_W:0] smp, thr;
   logic close, idle_eff;

   // one extra bit so +H and -H are both representable as signed values
   assign thr = $signed({1'b0, hyst});
   assign close = S_AXIS_IN_tvalid && gate_cnt == (shadow == 32'd0 ? 32'd0 : shadow - 32'd1);
   // a tlast handshake in the closing cycle frees the frame buffer just in time
   assign idle_eff = state == IDLE || (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready && M_AXIS_OUT_tlast);
   assign M_AXIS_OUT_tvalid = state == SEND;
   assign M_AXIS_OUT_tlast = state == SEND && idx == 3'(CH - 1);
   assign M_AXIS_OUT_tuser = idx;

   always_comb begin
      smp = '0;
      hi_nxt = hi;
      cnt_nxt = cnt;
      for (int c = 0; c < CH; c++) begin
         smp = (DATA_W + 1)'($signed(S_AXIS_IN_tdata[c*DATA_W +: DATA_W]));
         if (S_AXIS_IN_tvalid && !hi[c] && smp > thr) begin
            hi_nxt[c] = 1'b1;
            if (~&cnt[c*CNT_W +: CNT_W]) cnt_nxt[c*CNT_W +: CNT_W] = cnt[c*CNT_W +: CNT_W] + CNT_W'(1);
         end else if (S_AXIS_IN_tvalid && hi[c] && smp < -thr)
            hi_nxt[c] = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt = idx;
      M_AXIS_OUT_tdata = '0;
      for (int c = 0; c < CH; c++)
         if (state == SEND && idx == 3'(c)) M_AXIS_OUT_tdata = counter_output[c*CNT_W +: CNT_W];
      if (close && idle_eff) begin
         state_nxt = SEND;
         idx_nxt = 3'd0;
      end else if (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready) begin
         state_nxt = M_AXIS_OUT_tlast ? IDLE : SEND;
         idx_nxt = M_AXIS_OUT_tlast ? 3'd0 : idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         idx <= 3'd0;
      end else begin
         state <= state_nxt;
         idx <= idx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi <= '0;
         cnt <= '0;
         gate_cnt <= 32'd0;
         shadow <= Ncycles;
         counter_output <= '0;
         overrun <= 1'b0;
      end else begin
         hi <= hi_nxt;
         if (close) begin
            cnt <= '0;
            gate_cnt <= 32'd0;
            shadow <= Ncycles;
            if (idle_eff) counter_output <= cnt_nxt;
         end else begin
            cnt <= cnt_nxt;
            if (S_AXIS_IN_tvalid) gate_cnt <= gate_cnt + 32'd1;
         end
         overrun <= (close && !idle_eff) || (overrun && !clr_ovr);
      end
   end
endmodule

// File: tb/tb_freq_counter_mc.sv
// tb_freq_counter_mc: directed scoreboard bench for freq_counter_mc (2-channel main
// instance plus a 1-channel 4-bit-counter instance for saturation).
module tb_freq_counter_mc;
   logic clk, rst, S_AXIS_IN_tvalid, clr_ovr, M_AXIS_OUT_tready;
   logic [31:0] S_AXIS_IN_tdata, Ncycles, sat_n;
   logic [15:0] hyst, sat_tdata;
   logic [31:0] M_AXIS_OUT_tdata;
   logic [2:0] M_AXIS_OUT_tuser, sat_user;
   logic M_AXIS_OUT_tlast, M_AXIS_OUT_tvalid, overrun;
   logic [63:0] counter_output;
   logic sat_valid, sat_last, sat_vo, sat_ovr;
   logic [3:0] sat_data, sat_cnt;
   logic [35:0] q[$];
   logic [7:0] sq[$];
   int vectors = 0, miscompares = 0;

   freq_counter_mc #(.DATA_W(16), .CH(2), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .S_AXIS_IN_tdata(S_AXIS_IN_tdata), .S_AXIS_IN_tvalid(S_AXIS_IN_tvalid),
      .Ncycles(Ncycles), .hyst(hyst), .clr_ovr(clr_ovr), .M_AXIS_OUT_tdata(M_AXIS_OUT_tdata),
      .M_AXIS_OUT_tuser(M_AXIS_OUT_tuser), .M_AXIS_OUT_tlast(M_AXIS_OUT_tlast),
      .M_AXIS_OUT_tvalid(M_AXIS_OUT_tvalid), .M_AXIS_OUT_tready(M_AXIS_OUT_tready),
      .counter_output(counter_output), .overrun(overrun));

   freq_counter_mc #(.DATA_W(16), .CH(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .S_AXIS_IN_tdata(sat_tdata), .S_AXIS_IN_tvalid(sat_valid),
      .Ncycles(sat_n), .hyst(hyst), .clr_ovr(1'b0), .M_AXIS_OUT_tdata(sat_data),
      .M_AXIS_OUT_tuser(sat_user), .M_AXIS_OUT_tlast(sat_last), .M_AXIS_OUT_tvalid(sat_vo),
      .M_AXIS_OUT_tready(1'b1), .counter_output(sat_cnt), .overrun(sat_ovr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int a, input int b, input bit v);
      S_AXIS_IN_tdata = {16'(b), 16'(a)};
      S_AXIS_IN_tvalid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c0, input int c1);
      q.push_back({1'b0, 3'd0, 32'(c0)});
      q.push_back({1'b1, 3'd1, 32'(c1)});
   endtask

   function automatic int sine(input int k, input int n);
      return int'(770.0 * $sin(6.283185307179586 * real'(k) / real'(n)));
   endfunction

   always @(negedge clk) begin
      if (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready) begin
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", {M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata});
         end else check("word", {M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, q.pop_front());
      end
      if (sat_vo) begin
         if (sq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_sat_word: got 0x%0h, expected no word", {sat_last, sat_user, sat_data});
         end else check("sat_word", {sat_last, sat_user, sat_data}, sq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int da[4] = '{200, -200, 200, 0};
      int db[4] = '{0, 200, -200, 0};
      int ea[4] = '{-200, 200, 0, 0};
      int eb[4] = '{200, 0, -200, 0};
      int ga[5] = '{200, -200, 200, 0, 0};
      int gb[5] = '{0, 200, -200, 200, 0};
      rst = 1'b0; S_AXIS_IN_tdata = '0; S_AXIS_IN_tvalid = 1'b0; Ncycles = 32'd300; hyst = 16'd100;
      clr_ovr = 1'b0; M_AXIS_OUT_tready = 1'b1; sat_valid = 1'b0; sat_tdata = '0; sat_n = 32'd64;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", {M_AXIS_OUT_tvalid, M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, 0);
      check("rst_cnt", counter_output, 0);
      check("rst_ovr", overrun, 0);
      rst = 1'b1;
      // basic count, with a mid-gate Ncycles change that only affects the next gate
      push(10, 20);
      for (int k = 0; k < 300; k++) begin
         if (k == 150) Ncycles = 32'd60;
         drive(sine(k % 30, 30), sine(k % 15, 15), 1'b1);
         if (k == 298) check("a_open", M_AXIS_OUT_tvalid, 0);
      end
      check("a_close", M_AXIS_OUT_tvalid, 1);
      check("a_cnt", counter_output, {32'd20, 32'd10});
      // hysteresis reject, 60-sample gate
      Ncycles = 32'd100;
      push(0, 0);
      for (int k = 0; k < 60; k++) begin
         drive(((k / 5) % 2) ? -50 : 50, 0, 1'b1);
         if (k == 58) check("b_open", M_AXIS_OUT_tvalid, 0);
      end
      check("b_close", M_AXIS_OUT_tvalid, 1);
      check("b_ovr", overrun, 0);
      // above-hysteresis square, 100-sample gate
      Ncycles = 32'd0;
      push(10, 0);
      for (int k = 0; k < 100; k++) begin
         drive(((k / 5) % 2) ? -150 : 150, 0, 1'b1);
         if (k == 98) check("c_open", M_AXIS_OUT_tvalid, 0);
      end
      check("c_close", M_AXIS_OUT_tvalid, 1);
      check("c_cnt", counter_output, {32'd0, 32'd10});
      drive(0, 0, 1'b0);
      drive(0, 0, 1'b0);
      // Ncycles=0: one frame per accepted sample, gaps ignored, back-to-back frames
      push(1, 0); push(0, 1); push(1, 0); push(0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) Ncycles = 32'd4;
         drive(da[i], db[i], 1'b1);
         check("d_valid", M_AXIS_OUT_tvalid, 1);
         if (i < 3) begin
            drive(1000, 1000, 1'b0);
            check("d_gap_valid", M_AXIS_OUT_tvalid, 1);
         end
      end
      check("d_ovr", overrun, 0);
      // 4-sample gate with 50% input valid
      push(1, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) Ncycles = 32'd1;
         drive(ea[i], eb[i], 1'b1);
         if (i < 3) drive(1000, 1000, 1'b0);
         if (i == 2) check("e_open", M_AXIS_OUT_tvalid, 0);
      end
      check("e_close", M_AXIS_OUT_tvalid, 1);
      drive(0, 0, 1'b0);
      drive(0, 0, 1'b0);
      // backpressure, dropped gates, overrun set/clear priority
      M_AXIS_OUT_tready = 1'b0;
      push(0, 1);
      drive(-200, 200, 1'b1);
      check("f_hold1", {M_AXIS_OUT_tvalid, M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, {1'b1, 36'd0});
      drive(200, -200, 1'b1);
      check("f_ovr_set", overrun, 1);
      check("f_cnt_kept", counter_output, {32'd1, 32'd0});
      check("f_hold2", {M_AXIS_OUT_tvalid, M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, {1'b1, 36'd0});
      clr_ovr = 1'b1;
      drive(0, 0, 1'b0);
      check("f_ovr_clr", overrun, 0);
      drive(-200, 200, 1'b1);
      check("f_ovr_wins", overrun, 1);
      clr_ovr = 1'b0;
      drive(0, 0, 1'b0);
      check("f_hold3", {M_AXIS_OUT_tvalid, M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, {1'b1, 36'd0});
      M_AXIS_OUT_tready = 1'b1;
      drive(0, 0, 1'b0);
      drive(0, 0, 1'b0);
      check("f_idle", M_AXIS_OUT_tvalid, 0);
      check("f_cnt_after", counter_output, {32'd1, 32'd0});
      check("f_ovr_sticky", overrun, 1);
      clr_ovr = 1'b1;
      drive(0, 0, 1'b0);
      clr_ovr = 1'b0;
      check("f_ovr_cleared", overrun, 0);
      // reset in the middle of a held frame
      M_AXIS_OUT_tready = 1'b0;
      drive(0, 0, 1'b1);
      Ncycles = 32'd5;
      drive(0, 0, 1'b1);
      check("g_ovr", overrun, 1);
      check("g_valid", M_AXIS_OUT_tvalid, 1);
      rst = 1'b0;
      drive(200, 200, 1'b1);
      check("g_rst_out", {M_AXIS_OUT_tvalid, M_AXIS_OUT_tlast, M_AXIS_OUT_tuser, M_AXIS_OUT_tdata}, 0);
      check("g_rst_cnt", counter_output, 0);
      check("g_rst_ovr", overrun, 0);
      rst = 1'b1;
      M_AXIS_OUT_tready = 1'b1;
      push(2, 2);
      for (int i = 0; i < 5; i++) begin
         drive(ga[i], gb[i], 1'b1);
         if (i == 3) check("g_open", M_AXIS_OUT_tvalid, 0);
      end
      check("g_close", M_AXIS_OUT_tvalid, 1);
      // saturation on the 4-bit instance: 32 crossings clip to 15
      sq.push_back({1'b1, 3'd0, 4'd15});
      for (int k = 0; k < 64; k++) begin
         sat_tdata = (k % 2) ? 16'hff38 : 16'd200;
         sat_valid = 1'b1;
         drive(0, 0, 1'b0);
         if (k == 62) check("h_open", sat_vo, 0);
      end
      sat_valid = 1'b0;
      check("h_close", sat_vo, 1);
      for (int i = 0; i < 20 && (q.size() != 0 || sq.size() != 0); i++) @(posedge clk);
      #1;
      check("queue_drain", 64'(q.size() + sq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
